// File: rtl/register_mp_pkg.sv
// Shared types for the multi-port register file.
//   rf_state_t              : sweep/idle FSM state
//   register_mp_read_in_t   : one read request (enable + address)
//   register_mp_read_out_t  : one read result (data + pending flag)
//   register_mp_write_in_t  : one write request (enable + address + data)
// Struct widths follow the default configuration (RF_XLEN/RF_AW).
package register_mp_pkg;

  localparam int unsigned RF_XLEN  = 32;
  localparam int unsigned RF_DEPTH = 32;
  localparam int unsigned RF_AW    = $clog2(RF_DEPTH);

  typedef enum logic {
    RF_CLEAR,
    RF_IDLE
  } rf_state_t;

  typedef struct packed {
    logic             en;
    logic [RF_AW-1:0] addr;
  } register_mp_read_in_t;

  typedef struct packed {
    logic [RF_XLEN-1:0] data;
    logic               pend;
  } register_mp_read_out_t;

  typedef struct packed {
    logic               en;
    logic [RF_AW-1:0]   addr;
    logic [RF_XLEN-1:0] data;
  } register_mp_write_in_t;

endpackage

// File: rtl/register_mp_if.sv
// Access bundle for register_mp.
//   master : issue/writeback side (drives reads, writes, scoreboard set, clear)
//   slave  : register file side (returns rdata, rpend, ready)
interface register_mp_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned NRD   = 4,
  parameter int unsigned NWR   = 2
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NRD-1:0]           rden;
  logic [NRD-1:0][AW-1:0]   raddr;
  logic [NRD-1:0][XLEN-1:0] rdata;
  logic [NRD-1:0]           rpend;
  logic [NWR-1:0]           wren;
  logic [NWR-1:0][AW-1:0]   waddr;
  logic [NWR-1:0][XLEN-1:0] wdata;
  logic                     sb_set;
  logic [AW-1:0]            sb_addr;
  logic                     clear;
  logic                     ready;

  modport master (
    output rden, raddr, wren, waddr, wdata, sb_set, sb_addr, clear,
    input  rdata, rpend, ready
  );

  modport slave (
    input  rden, raddr, wren, waddr, wdata, sb_set, sb_addr, clear,
    output rdata, rpend, ready
  );
endinterface

// File: rtl/register_mp_wsel.sv
// Write-port priority select for one address.
//   wren_i/waddr_i/wdata_i : all write ports
//   addr_i                 : address of interest
//   hit_o                  : some enabled port targets addr_i
//   data_o                 : data of the highest-index matching port
// Writes to register 0 never hit when ZERO_REG is set.
module register_mp_wsel
  import register_mp_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [NWR-1:0]           wren_i,
  input  logic [NWR-1:0][AW-1:0]   waddr_i,
  input  logic [NWR-1:0][XLEN-1:0] wdata_i,
  input  logic [AW-1:0]            addr_i,
  output logic                     hit_o,
  output logic [XLEN-1:0]          data_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    // Ascending scan: a later (higher-index) match overrides earlier ones.
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wren_i[j] && (waddr_i[j] == addr_i) && !((ZERO_REG != 0) && (addr_i == '0))) begin
        hit_o  = 1'b1;
        data_o = wdata_i[j];
      end
    end
  end

endmodule

// File: rtl/register_mp.sv
// Multi-port integer register file with bypass, pending scoreboard and a
// sequential clear sweep (after reset or on request).
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   rf  : slave side of register_mp_if (reads, writes, sb_set, clear, ready)
module register_mp
  import register_mp_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NRD      = 4,
  parameter int unsigned NWR      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  register_mp_if.slave rf
);
  localparam int unsigned AW = $clog2(DEPTH);

  rf_state_t       state_q;
  logic [AW-1:0]   cnt_q;
  logic            ready_q;
  logic [XLEN-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q;

  logic [DEPTH-1:0] whit;
  logic [XLEN-1:0]  wdat [DEPTH];
  logic [NRD-1:0]   bhit;
  logic [XLEN-1:0]  bdat [NRD];
  logic             sb_ok;

  logic [NRD-1:0][XLEN-1:0] rdata_c;
  logic [NRD-1:0]           rpend_c;

  for (genvar a = 0; a < DEPTH; a++) begin : g_wr
    register_mp_wsel #(.XLEN(XLEN), .AW(AW), .NWR(NWR), .ZERO_REG(ZERO_REG)) u_wsel (
      .wren_i (rf.wren),
      .waddr_i(rf.waddr),
      .wdata_i(rf.wdata),
      .addr_i (AW'(a)),
      .hit_o  (whit[a]),
      .data_o (wdat[a])
    );
  end

  for (genvar i = 0; i < NRD; i++) begin : g_byp
    register_mp_wsel #(.XLEN(XLEN), .AW(AW), .NWR(NWR), .ZERO_REG(ZERO_REG)) u_wsel (
      .wren_i (rf.wren),
      .waddr_i(rf.waddr),
      .wdata_i(rf.wdata),
      .addr_i (rf.raddr[i]),
      .hit_o  (bhit[i]),
      .data_o (bdat[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= RF_IDLE;
            ready_q <= 1'b1;
          end
        end
        RF_IDLE: begin
          if (rf.clear) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= RF_CLEAR;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Data array carries no reset: the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (state_q == RF_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        if (whit[a]) mem_q[a] <= wdat[a];
      end
    end
  end

  assign sb_ok = rf.sb_set && !((ZERO_REG != 0) && (rf.sb_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
    end else if (state_q == RF_CLEAR) begin
      pend_q[cnt_q] <= 1'b0;
    end else begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        // Set is applied after the write clear so it wins on a collision.
        if (whit[a]) pend_q[a] <= 1'b0;
        if (sb_ok && (rf.sb_addr == AW'(a))) pend_q[a] <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    rpend_c = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if ((state_q == RF_IDLE) && rf.rden[i] &&
          !((ZERO_REG != 0) && (rf.raddr[i] == '0))) begin
        if ((BYPASS != 0) && bhit[i]) begin
          rdata_c[i] = bdat[i];
        end else begin
          rdata_c[i] = mem_q[rf.raddr[i]];
          rpend_c[i] = pend_q[rf.raddr[i]];
        end
      end
    end
  end

  assign rf.rdata = rdata_c;
  assign rf.rpend = rpend_c;
  assign rf.ready = ready_q;

endmodule

// File: tb/tb_register_mp.sv
// Self-checking bench for register_mp (default parameters).
module tb_register_mp;
  import register_mp_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  register_mp_if #(.XLEN(32), .DEPTH(32), .NRD(4), .NWR(2)) rf ();

  register_mp #(
    .XLEN(32), .DEPTH(32), .NRD(4), .NWR(2), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rf (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mem   [32];
  bit          mpend [32];
  bit          mready;
  int          mcnt;

  register_mp_read_out_t sb_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    rf.wren    = '0;
    rf.waddr   = '0;
    rf.wdata   = '0;
    rf.sb_set  = 1'b0;
    rf.sb_addr = '0;
    rf.clear   = 1'b0;
  endtask

  task automatic rd_all(input int a);
    rf.rden = '1;
    for (int i = 0; i < 4; i++) rf.raddr[i] = 5'(a);
  endtask

  task automatic model_reset();
    mready = 1'b0;
    mcnt   = 0;
    for (int a = 0; a < 32; a++) mpend[a] = 1'b0;
  endtask

  // One clock: predict reads, compare, then advance the model on the edge.
  task automatic cycle();
    register_mp_read_out_t e;
    chk("ready", 64'(rf.ready), 64'(mready));
    for (int i = 0; i < 4; i++) begin
      e.data = '0;
      e.pend = 1'b0;
      if (mready && rf.rden[i] && rf.raddr[i] != 5'd0) begin
        e.data = mem[rf.raddr[i]];
        e.pend = mpend[rf.raddr[i]];
        for (int j = 0; j < 2; j++) begin
          if (rf.wren[j] && rf.waddr[j] == rf.raddr[i]) begin
            e.data = rf.wdata[j];
            e.pend = 1'b0;
          end
        end
      end
      sb_q.push_back(e);
    end
    #2;
    for (int i = 0; i < 4; i++) begin
      e = sb_q.pop_front();
      chk($sformatf("rdata%0d@%0d", i, rf.raddr[i]), 64'(rf.rdata[i]), 64'(e.data));
      chk($sformatf("rpend%0d@%0d", i, rf.raddr[i]), 64'(rf.rpend[i]), 64'(e.pend));
    end
    @(posedge clk);
    if (!mready) begin
      mem[mcnt]   = '0;
      mpend[mcnt] = 1'b0;
      if (mcnt == 31) mready = 1'b1;
      mcnt = (mcnt + 1) % 32;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (rf.wren[j] && rf.waddr[j] != 5'd0) begin
          mem[rf.waddr[j]]   = rf.wdata[j];
          mpend[rf.waddr[j]] = 1'b0;
        end
      end
      if (rf.sb_set && rf.sb_addr != 5'd0) mpend[rf.sb_addr] = 1'b1;
      if (rf.clear) begin
        mready = 1'b0;
        mcnt   = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic sweep_wait(input int exp_len);
    int n;
    n = 0;
    while (!rf.ready && n < 100) begin
      cycle();
      n++;
    end
    chk("sweep_len", 64'(n), 64'(exp_len));
  endtask

  task automatic reset_checks();
    #2;
    chk("rst_ready", 64'(rf.ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_rdata%0d", i), 64'(rf.rdata[i]), 64'd0);
      chk($sformatf("rst_rpend%0d", i), 64'(rf.rpend[i]), 64'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int a = 0; a < 32; a++) mem[a] = '0;
    model_reset();
    rst = 1'b0;
    idle_in();
    rd_all(5);
    #12;
    reset_checks();

    // Release and let the power-on sweep run
    @(negedge clk);
    rst = 1'b1;
    sweep_wait(32);

    // Every address reads zero after the sweep
    for (int a = 0; a < 32; a++) begin
      rd_all(a);
      cycle();
    end

    // Simple write then read on all ports
    rf.wren[0] = 1'b1; rf.waddr[0] = 5'd5; rf.wdata[0] = 32'hDEADBEEF;
    rd_all(1);
    cycle();
    idle_in();
    rd_all(5);
    cycle();

    // Same-address write collision, bypass picks port 1
    rf.wren = 2'b11;
    rf.waddr[0] = 5'd7; rf.wdata[0] = 32'h11;
    rf.waddr[1] = 5'd7; rf.wdata[1] = 32'h22;
    rd_all(7);
    cycle();
    idle_in();
    cycle();

    // Register 0 is hardwired
    rf.wren[0] = 1'b1; rf.waddr[0] = 5'd0; rf.wdata[0] = 32'hFFFF;
    rd_all(0);
    cycle();
    idle_in();
    cycle();

    // Scoreboard set, clear by write, set-wins collision
    rf.sb_set = 1'b1; rf.sb_addr = 5'd9;
    rd_all(9);
    cycle();
    idle_in();
    cycle();
    rf.wren[1] = 1'b1; rf.waddr[1] = 5'd9; rf.wdata[1] = 32'h33;
    cycle();
    idle_in();
    cycle();
    rf.sb_set = 1'b1; rf.sb_addr = 5'd9;
    rf.wren[0] = 1'b1; rf.waddr[0] = 5'd9; rf.wdata[0] = 32'h77;
    cycle();
    idle_in();
    cycle();
    rf.sb_set = 1'b1; rf.sb_addr = 5'd0;
    rd_all(0);
    cycle();
    idle_in();
    cycle();

    // Random traffic on a narrow address range to provoke collisions
    for (int k = 0; k < 40; k++) begin
      rf.wren    = 2'($urandom_range(0, 3));
      rf.sb_set  = 1'($urandom_range(0, 1));
      rf.sb_addr = 5'($urandom_range(0, 7));
      rf.rden    = 4'($urandom_range(0, 15));
      for (int j = 0; j < 2; j++) begin
        rf.waddr[j] = 5'($urandom_range(0, 7));
        rf.wdata[j] = $urandom;
      end
      for (int i = 0; i < 4; i++) rf.raddr[i] = 5'($urandom_range(0, 7));
      cycle();
    end
    idle_in();

    // Requested clear sweep; writes during the sweep are dropped
    rf.wren[0] = 1'b1; rf.waddr[0] = 5'd3; rf.wdata[0] = 32'h44;
    rd_all(2);
    cycle();
    idle_in();
    rd_all(3);
    cycle();
    rf.clear = 1'b1;
    cycle();
    idle_in();
    rf.wren[0] = 1'b1; rf.waddr[0] = 5'd3; rf.wdata[0] = 32'h55;
    rf.clear = 1'b1;
    sweep_wait(32);
    idle_in();
    cycle();
    rd_all(9);
    cycle();

    // Reset in the middle of a sweep restarts it from the beginning
    rf.clear = 1'b1;
    cycle();
    idle_in();
    rd_all(3);
    for (int k = 0; k < 10; k++) cycle();
    chk("mid_cnt_model", 64'(mcnt), 64'd10);
    rst = 1'b0;
    model_reset();
    reset_checks();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sweep_wait(32);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
